// File: rtl/dsp_seq.sv
// ADC-to-FIR sample gate and frame sequencer with fx-bus register file.
// Discards FIR warm-up outputs, then frames LEN filtered samples (optionally back-to-back).
module dsp_seq #(
  parameter logic [15:0] BASE     = 16'h0020,
  parameter logic [7:0]  SKIP_RST = 8'd31
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic [5:0]  i_dev_id,
  input  logic        i_fx_wr,
  input  logic [21:0] i_fx_waddr,
  input  logic [7:0]  i_fx_data,
  input  logic        i_fx_rd,
  input  logic [21:0] i_fx_raddr,
  output logic [7:0]  o_fx_q,
  input  logic [15:0] i_ad_data,
  input  logic        i_ad_vld,
  output logic [15:0] o_fir_data,
  output logic        o_fir_vld,
  input  logic [15:0] i_fir_q,
  input  logic        i_fir_qvld,
  output logic [15:0] o_sm_data,
  output logic        o_sm_vld,
  output logic        o_sm_sof,
  output logic        o_sm_eof,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {StIdle, StWarm, StRun, StDone} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_cont, r_cont_act, w_cont_act_nxt;
  logic [15:0] r_len, r_len_act, w_len_act_nxt;
  logic [7:0]  r_skip, r_skip_act, w_skip_act_nxt;
  logic [7:0]  r_warm, w_warm_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_done, w_done_nxt, r_err, w_err_nxt, r_abt, w_abt_nxt;
  logic [15:0] r_sm_data, w_sm_data_nxt;
  logic        r_sm_vld, w_sm_vld_nxt, r_sm_sof, w_sm_sof_nxt, r_sm_eof, w_sm_eof_nxt;
  logic [15:0] r_fir_data;
  logic        r_fir_vld;
  logic [7:0]  r_fx_q, w_rdata;

  logic [15:0] w_woff, w_roff;
  logic        w_wr_hit, w_rd_hit;
  logic [6:0]  w_wsel;
  logic        w_start, w_abort, w_busy, w_busy_nxt, w_eof;

  // Register offsets are taken modulo 2^16 so BASE near the top still decodes consistently.
  assign w_woff   = i_fx_waddr[15:0] - BASE;
  assign w_roff   = i_fx_raddr[15:0] - BASE;
  assign w_wr_hit = i_fx_wr && (i_fx_waddr[21:16] == i_dev_id);
  assign w_rd_hit = i_fx_rd && (i_fx_raddr[21:16] == i_dev_id);

  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < 7; i++) begin
      w_wsel[i] = w_wr_hit && (w_woff == 16'(i));
    end
  end

  assign w_start    = w_wsel[0] && i_fx_data[0];
  assign w_abort    = w_wsel[0] && i_fx_data[1];
  assign w_busy     = (r_state == StWarm) || (r_state == StRun);
  assign w_busy_nxt = (w_state_nxt == StWarm) || (w_state_nxt == StRun);
  assign w_eof      = (r_cnt == r_len_act - 16'd1);

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cont <= 1'b0;
      r_len  <= '0;
      r_skip <= SKIP_RST;
    end else begin
      if (w_wsel[0]) r_cont <= i_fx_data[2];
      if (w_wsel[1]) r_len[7:0] <= i_fx_data;
      if (w_wsel[2]) r_len[15:8] <= i_fx_data;
      if (w_wsel[3]) r_skip <= i_fx_data;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_warm_nxt     = r_warm;
    w_len_act_nxt  = r_len_act;
    w_skip_act_nxt = r_skip_act;
    w_cont_act_nxt = r_cont_act;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_abt_nxt      = r_abt;
    w_sm_data_nxt  = r_sm_data;
    w_sm_vld_nxt   = 1'b0;
    w_sm_sof_nxt   = 1'b0;
    w_sm_eof_nxt   = 1'b0;

    if (w_wsel[4]) begin
      if (i_fx_data[1]) w_done_nxt = 1'b0;
      if (i_fx_data[2]) w_err_nxt = 1'b0;
      if (i_fx_data[3]) w_abt_nxt = 1'b0;
    end

    if (w_abort) begin
      w_state_nxt = StIdle;
      w_abt_nxt   = 1'b1;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (r_state == StDone) w_state_nxt = StIdle;
          if (w_start) begin
            if (r_len == 16'd0) begin
              w_err_nxt = 1'b1;
            end else begin
              w_done_nxt     = 1'b0;
              w_abt_nxt      = 1'b0;
              w_cnt_nxt      = '0;
              w_warm_nxt     = '0;
              w_len_act_nxt  = r_len;
              w_skip_act_nxt = r_skip;
              w_cont_act_nxt = i_fx_data[2];
              w_state_nxt    = (r_skip == 8'd0) ? StRun : StWarm;
            end
          end
        end
        StWarm: begin
          if (i_fir_qvld) begin
            w_warm_nxt = r_warm + 8'd1;
            if (r_warm == r_skip_act - 8'd1) w_state_nxt = StRun;
          end
        end
        StRun: begin
          if (i_fir_qvld) begin
            w_sm_vld_nxt  = 1'b1;
            w_sm_data_nxt = i_fir_q;
            w_sm_sof_nxt  = (r_cnt == 16'd0);
            w_sm_eof_nxt  = w_eof;
            w_cnt_nxt     = r_cnt + 16'd1;
            if (w_eof) begin
              if (r_cont_act) begin
                // Continuous mode: new frame picks up any LEN/CONT written meanwhile.
                w_cnt_nxt      = '0;
                w_len_act_nxt  = r_len;
                w_cont_act_nxt = r_cont;
              end else begin
                w_state_nxt = StDone;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_warm     <= '0;
      r_len_act  <= '0;
      r_skip_act <= '0;
      r_cont_act <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_abt      <= 1'b0;
      r_sm_data  <= '0;
      r_sm_vld   <= 1'b0;
      r_sm_sof   <= 1'b0;
      r_sm_eof   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_warm     <= w_warm_nxt;
      r_len_act  <= w_len_act_nxt;
      r_skip_act <= w_skip_act_nxt;
      r_cont_act <= w_cont_act_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_abt      <= w_abt_nxt;
      r_sm_data  <= w_sm_data_nxt;
      r_sm_vld   <= w_sm_vld_nxt;
      r_sm_sof   <= w_sm_sof_nxt;
      r_sm_eof   <= w_sm_eof_nxt;
    end
  end

  // Gate on the next state too, so leaving WARM/RUN stops fir_vld without a trailing sample.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fir_data <= '0;
      r_fir_vld  <= 1'b0;
    end else begin
      r_fir_vld <= w_busy && w_busy_nxt && i_ad_vld;
      if (w_busy) r_fir_data <= i_ad_data;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_roff)
      16'd0:   w_rdata = {5'b0, r_cont, 2'b0};
      16'd1:   w_rdata = r_len[7:0];
      16'd2:   w_rdata = r_len[15:8];
      16'd3:   w_rdata = r_skip;
      16'd4:   w_rdata = {4'b0, r_abt, r_err, r_done, w_busy};
      16'd5:   w_rdata = r_cnt[7:0];
      16'd6:   w_rdata = r_cnt[15:8];
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fx_q <= '0;
    end else begin
      r_fx_q <= w_rd_hit ? w_rdata : 8'd0;
    end
  end

  assign o_fx_q     = r_fx_q;
  assign o_fir_data = r_fir_data;
  assign o_fir_vld  = r_fir_vld;
  assign o_sm_data  = r_sm_data;
  assign o_sm_vld   = r_sm_vld;
  assign o_sm_sof   = r_sm_sof;
  assign o_sm_eof   = r_sm_eof;
  assign o_busy     = w_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_dsp_seq.sv
// Directed bench for dsp_seq: expected framed stream comes from a queue model built
// from skip/len/cont rules; every clock the framed output is checked against it.
module tb_dsp_seq;

  localparam logic [15:0] BASE = 16'h0020;
  localparam logic [5:0]  DEV  = 6'h2A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  dev_id;
  logic        fx_wr, fx_rd;
  logic [21:0] fx_waddr, fx_raddr;
  logic [7:0]  fx_data, fx_q;
  logic [15:0] ad_data, fir_data, fir_q, sm_data;
  logic        ad_vld, fir_vld, fir_qvld, sm_vld, sm_sof, sm_eof, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eof;
  } exp_t;
  exp_t exp_q[$];

  dsp_seq #(.BASE(BASE), .SKIP_RST(8'd31)) dut (
    .i_clk_sys (clk),      .i_rst_n   (rst_n),    .i_dev_id  (dev_id),
    .i_fx_wr   (fx_wr),    .i_fx_waddr(fx_waddr), .i_fx_data (fx_data),
    .i_fx_rd   (fx_rd),    .i_fx_raddr(fx_raddr), .o_fx_q    (fx_q),
    .i_ad_data (ad_data),  .i_ad_vld  (ad_vld),   .o_fir_data(fir_data),
    .o_fir_vld (fir_vld),  .i_fir_q   (fir_q),    .i_fir_qvld(fir_qvld),
    .o_sm_data (sm_data),  .o_sm_vld  (sm_vld),   .o_sm_sof  (sm_sof),
    .o_sm_eof  (sm_eof),   .o_busy    (busy),     .o_done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected framed stream for n consecutive FIR outputs base, base+1, ...
  task automatic model(input int skip, input int len, input bit cont,
                       input logic [15:0] base, input int n);
    exp_t e;
    int   j;
    for (int k = 0; k < n; k++) begin
      if (k < skip) continue;
      j = k - skip;
      if (!cont && j >= len) break;
      e.d   = base + 16'(k);
      e.sof = (j % len) == 0;
      e.eof = (j % len) == len - 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sm_vld) begin
      if (exp_q.size() == 0) begin
        check("sm_unexpected_vld", sm_vld, 0);
      end else begin
        e = exp_q.pop_front();
        check("sm_data", sm_data, e.d);
        check("sm_sof", sm_sof, e.sof);
        check("sm_eof", sm_eof, e.eof);
      end
    end
  endtask

  task automatic wr(input int n, input logic [7:0] d, input logic [5:0] dev = DEV);
    fx_wr    = 1'b1;
    fx_waddr = {dev, BASE + 16'(n)};
    fx_data  = d;
    tick();
    fx_wr    = 1'b0;
  endtask

  task automatic rd(input int n, input logic [5:0] dev, output logic [7:0] v);
    fx_rd    = 1'b1;
    fx_raddr = {dev, BASE + 16'(n)};
    tick();
    v        = fx_q;
    fx_rd    = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int n, input logic [7:0] exp);
    logic [7:0] v;
    rd(n, DEV, v);
    check(name, v, exp);
  endtask

  task automatic fir(input logic [15:0] v);
    fir_q    = v;
    fir_qvld = 1'b1;
    tick();
    fir_qvld = 1'b0;
    tick();
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_fx_q"}, fx_q, 0);
    check({tag, "_fir_data"}, fir_data, 0);
    check({tag, "_fir_vld"}, fir_vld, 0);
    check({tag, "_sm_data"}, sm_data, 0);
    check({tag, "_sm_vld"}, sm_vld, 0);
    check({tag, "_sm_sof"}, sm_sof, 0);
    check({tag, "_sm_eof"}, sm_eof, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b1; dev_id = DEV;
    fx_wr = 0; fx_rd = 0; fx_waddr = '0; fx_raddr = '0; fx_data = '0;
    ad_data = '0; ad_vld = 0; fir_q = '0; fir_qvld = 0;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    rd_chk("skip_reset", 3, 8'd31);
    rd_chk("status_reset", 4, 8'h00);
    tick();
    check("fx_q_no_rd", fx_q, 0);

    // START with LEN==0: error, no activity
    wr(0, 8'h01);
    check("len0_busy", busy, 0);
    rd_chk("len0_status", 4, 8'h04);
    wr(4, 8'h04);
    rd_chk("err_cleared", 4, 8'h00);

    // LEN=4, SKIP=2 single frame
    wr(1, 8'd4);
    wr(3, 8'd2);
    model(2, 4, 0, 16'h0001, 8);
    check("model_len4_n", exp_q.size(), 4);
    check("model_len4_first", exp_q[0].d, 16'h0003);
    check("model_len4_eof", exp_q[3].eof, 1);
    wr(0, 8'h01);
    check("warm_busy", busy, 1);
    ad_data = 16'hABCD; ad_vld = 1'b1;
    tick();
    check("fir_pass_vld", fir_vld, 1);
    check("fir_pass_data", fir_data, 16'hABCD);
    ad_vld = 1'b0;
    tick();
    check("fir_pass_gap", fir_vld, 0);
    for (int i = 1; i <= 8; i++) fir(16'(i));
    check("frame_done", done, 1);
    check("frame_busy", busy, 0);
    check("frame_drained", exp_q.size(), 0);
    rd_chk("status_done", 4, 8'h02);
    rd_chk("cnt_frame", 5, 8'd4);
    ad_vld = 1'b1;
    tick();
    tick();
    check("fir_gated_idle", fir_vld, 0);
    ad_vld = 1'b0;

    // LEN=3, SKIP=0, CONT=1: back-to-back frames
    wr(4, 8'h0E);
    wr(1, 8'd3);
    wr(3, 8'd0);
    model(0, 3, 1, 16'h0010, 7);
    check("model_cont_sof3", exp_q[3].sof, 1);
    check("model_cont_eof5", exp_q[5].eof, 1);
    check("model_cont_sof6", exp_q[6].sof, 1);
    wr(0, 8'h05);
    for (int i = 0; i < 7; i++) fir(16'h0010 + 16'(i));
    check("cont_busy", busy, 1);
    check("cont_drained", exp_q.size(), 0);
    rd_chk("cont_cnt", 5, 8'd1);
    wr(0, 8'h02);
    check("cont_abort_busy", busy, 0);
    rd_chk("cont_abort_status", 4, 8'h08);

    // ABORT mid-RUN at CNT=2; ABORT beats START
    wr(4, 8'h0E);
    wr(0, 8'h03);
    check("abort_wins", busy, 0);
    rd_chk("abort_wins_status", 4, 8'h08);
    wr(4, 8'h0E);
    wr(1, 8'd5);
    model(0, 5, 0, 16'h0020, 2);
    wr(0, 8'h01);
    fir(16'h0020);
    fir(16'h0021);
    rd_chk("abort_cnt", 5, 8'd2);
    wr(0, 8'h02);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rd_chk("abort_status", 4, 8'h08);
    for (int i = 0; i < 3; i++) begin
      fir_q = 16'h0077; fir_qvld = 1'b1;
      tick();
      check("drop_after_abort", sm_vld, 0);
      fir_qvld = 1'b0;
      tick();
    end
    check("abort_drained", exp_q.size(), 0);

    // LEN written while busy applies to the next frame only
    wr(4, 8'h0E);
    wr(1, 8'd2);
    model(0, 2, 0, 16'h0030, 4);
    wr(0, 8'h01);
    fir(16'h0030);
    wr(1, 8'd7);
    for (int i = 1; i < 4; i++) fir(16'h0030 + 16'(i));
    check("latched_len_done", done, 1);
    check("latched_len_drained", exp_q.size(), 0);

    // Foreign device id: no write, read gives 0
    wr(1, 8'h55, DEV ^ 6'h01);
    rd_chk("foreign_wr_ignored", 1, 8'd7);
    rd(1, DEV ^ 6'h01, v);
    check("foreign_rd_zero", v, 0);

    // Asynchronous reset in the middle of a frame
    wr(4, 8'h0E);
    wr(1, 8'd4);
    model(0, 4, 0, 16'h0040, 1);
    wr(0, 8'h01);
    fir_q = 16'h0040; fir_qvld = 1'b1; ad_data = 16'h5555; ad_vld = 1'b1;
    tick();
    fir_qvld = 1'b0;
    check("pre_rst_sm_vld", sm_vld, 1);
    check("pre_rst_fir_vld", fir_vld, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    ad_vld = 1'b0;
    rd_chk("rst_status", 4, 8'h00);
    rd_chk("rst_skip", 3, 8'd31);
    rd_chk("rst_len", 1, 8'h00);
    check("rst_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsp_seq.md
DSP_SEQ -- requirements
Module: dsp_seq

Interface
REQ-001 Parameter BASE, 16'h0020, low 16 address bits of register 0; registers occupy BASE..BASE+6.
REQ-002 Parameter SKIP_RST, 8'd31, reset value of SKIP register (FIR warm-up outputs discarded).
REQ-003 clk_sys  in  1  single system clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 dev_id  in  6  device id; register hit when addr[21:16]==dev_id and addr[15:0]==BASE+n.
REQ-006 fx_wr / fx_waddr / fx_data  in  1/22/8  fx-bus write strobe, address, data.
REQ-007 fx_rd / fx_raddr  in  1/22  fx-bus read strobe, address.
REQ-008 fx_q  out  8  read data.
REQ-009 ad_data / ad_vld  in  16/1  ADC sample stream.
REQ-010 fir_data / fir_vld  out  16/1  gated sample stream to FIR sink.
REQ-011 fir_q / fir_qvld  in  16/1  FIR source output.
REQ-012 sm_data / sm_vld  out  16/1  framed filtered stream.
REQ-013 sm_sof / sm_eof  out  1/1  first / last sample of frame, qualified by sm_vld.
REQ-014 busy / done  out  1/1  sequencer active; sticky frame-complete flag.

Function
REQ-015 Registers: n=0 CTRL (b0 START, b1 ABORT, b2 CONT; START/ABORT self-clear, read 0), n=1 LEN_L, n=2 LEN_H, n=3 SKIP, n=4 STATUS (b0 busy, b1 done, b2 err, b3 aborted; write 1 to b1-b3 clears), n=5 CNT_L, n=6 CNT_H (RO, samples output in current frame).
REQ-016 Write takes effect the cycle after fx_wr; read: fx_q registered, valid one cycle after fx_rd; non-hit or no fx_rd gives fx_q=0.
REQ-017 States IDLE, WARM, RUN, DONE; busy=1 in WARM and RUN.
REQ-018 IDLE: fir_vld=0, sm_vld=0; START with LEN!=0 -> WARM, clears done/aborted, CNT=0, warm counter=0.
REQ-019 START with LEN==0 -> stays IDLE, sets err; START while busy ignored, no flag change.
REQ-020 WARM/RUN: fir_data<=ad_data, fir_vld<=ad_vld, one-cycle registered latency.
REQ-021 WARM: each fir_qvld increments warm counter, sm_vld=0; on fir_qvld when warm count==SKIP-1 -> RUN; SKIP==0 enters RUN directly from IDLE on START.
REQ-022 RUN: on fir_qvld, sm_data<=fir_q, sm_vld<=1 next cycle, CNT increments; sm_sof with CNT==0 output; sm_eof when CNT==LEN-1.
REQ-023 On eof output: CONT=0 -> DONE (fir_vld forced 0 from next cycle); CONT=1 -> CNT=0, stay RUN, no re-warm.
REQ-024 DONE: set done, one cycle, -> IDLE; done held until cleared by STATUS write or START.
REQ-025 ABORT in any state -> IDLE next cycle, sets aborted, done unchanged, no eof emitted; ABORT wins over simultaneous START.
REQ-026 FIR outputs arriving in IDLE/DONE are discarded (sm_vld=0).
REQ-027 LEN/SKIP/CONT writes while busy take effect on next frame only (latched at START and at CONT frame wrap).
REQ-028 CNT 16-bit; LEN=16'hFFFF legal, no wrap within a frame.

Reset
REQ-029 rst_n low: state IDLE, all outputs 0, CTRL/LEN/STATUS/CNT=0, SKIP=SKIP_RST, effective immediately and asynchronously.
REQ-030 Reset mid-frame aborts without eof; aborted flag not set (cleared by reset).

Verification
REQ-031 LEN=4, SKIP=2, START, 8 FIR outputs 0x0001..0x0008 -> sm_data 0x0003..0x0006, sof on 0x0003, eof on 0x0006, done=1, fir_vld=0 afterwards.
REQ-032 LEN=0, START -> stays IDLE, busy=0, STATUS read = 0x04 one cycle after fx_rd.
REQ-033 LEN=3, SKIP=0, CONT=1, 7 FIR outputs -> sof on samples 1,4,7, eof on 3,6, busy stays 1.
REQ-034 ABORT mid-RUN with CNT=2 -> IDLE next cycle, no eof, STATUS=0x08, later FIR outputs dropped.
REQ-035 Write/read with fx_raddr[21:16]!=dev_id -> fx_q=0, registers unchanged; rst_n pulse mid-frame -> all outputs 0 immediately.
